// File: rtl/therm_to_code_pkg.sv
// Shared constants, FSM encoding and the majority helper for the
// thermometer-to-code readback block.
package therm_to_code_pkg;

  localparam int TW            = 16;
  localparam int CODE_W        = 5;
  localparam int ACC_W         = 7;
  localparam int NAVG_DEF      = 4;
  localparam int LOG_NAVG_DEF  = 2;
  localparam int MAX_RETRY_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/therm_bubble_count.sv
// Bubble-corrects a thermometer word with a 3-tap majority filter and
// counts the ones of the corrected word.
module therm_bubble_count
  import therm_to_code_pkg::*;
(
  input  logic [TW-1:0]     t,
  output logic [CODE_W-1:0] count,
  output logic              corrected
);

  logic [TW+1:0] ext;
  logic [TW-1:0] c;

  // Below tap 0 the line is taken as set and above the top tap as clear.
  assign ext = {1'b0, t, 1'b1};

  always_comb begin
    c     = '0;
    count = '0;
    for (int i = 0; i < TW; i++) begin
      c[i]  = maj3(ext[i], ext[i+1], ext[i+2]);
      count = count + CODE_W'(c[i]);
    end
  end

  assign corrected = (c != t);

endmodule

// File: rtl/therm_to_code.sv
// Samples the T/Tb tap pair NAVG times, rejects non-complementary samples,
// and reports the averaged bubble-corrected level with a fractional part.
module therm_to_code
  import therm_to_code_pkg::*;
#(
  parameter int NAVG      = NAVG_DEF,
  parameter int LOG_NAVG  = LOG_NAVG_DEF,
  parameter int MAX_RETRY = MAX_RETRY_DEF
) (
  input  logic                clk4,
  input  logic                rst_n,
  input  logic                start,
  input  logic                ack,
  input  logic [TW-1:0]       T_in,
  input  logic [TW-1:0]       Tb_in,
  output logic                busy,
  output logic                valid,
  output logic [CODE_W-1:0]   code_out,
  output logic [LOG_NAVG-1:0] code_frac,
  output logic                bubble,
  output logic                err
);

  localparam int CNT_W   = LOG_NAVG + 1;
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(NAVG - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);

  state_t               state, state_nxt;
  logic [TW-1:0]        t_r, tb_r;
  logic [ACC_W-1:0]     acc;
  logic [CNT_W-1:0]     cnt;
  logic [RETRY_W-1:0]   retry;
  logic                 bubble_acc, aborted, mismatch, corrected;
  logic [CODE_W-1:0]    count;

  therm_bubble_count u_count (
    .t         (t_r),
    .count     (count),
    .corrected (corrected)
  );

  assign mismatch = (tb_r != ~t_r);

  always_ff @(posedge clk4 or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_SAMPLE;
      ST_SAMPLE: state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (mismatch) state_nxt = (retry == RETRY_LAST) ? ST_DONE : ST_SAMPLE;
        else          state_nxt = (cnt == CNT_LAST)     ? ST_DONE : ST_SAMPLE;
      end
      // The result is published one cycle into DONE; ack counts only once it is visible.
      ST_DONE:   if (valid && ack) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_SAMPLE) || (state == ST_CHECK);
  end

  always_ff @(posedge clk4 or negedge rst_n) begin
    if (!rst_n) begin
      t_r        <= '0;
      tb_r       <= '0;
      acc        <= '0;
      cnt        <= '0;
      retry      <= '0;
      bubble_acc <= 1'b0;
      aborted    <= 1'b0;
      valid      <= 1'b0;
      code_out   <= '0;
      code_frac  <= '0;
      bubble     <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          acc        <= '0;
          cnt        <= '0;
          retry      <= '0;
          bubble_acc <= 1'b0;
          aborted    <= 1'b0;
        end
        ST_SAMPLE: begin
          t_r  <= T_in;
          tb_r <= Tb_in;
        end
        ST_CHECK: begin
          if (mismatch) begin
            retry <= retry + RETRY_W'(1);
            if (retry == RETRY_LAST) aborted <= 1'b1;
          end else begin
            retry      <= '0;
            acc        <= acc + ACC_W'(count);
            bubble_acc <= bubble_acc | corrected;
            cnt        <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (!valid) begin
            valid     <= 1'b1;
            err       <= aborted;
            bubble    <= bubble_acc;
            code_out  <= aborted ? '0 : CODE_W'(acc >> LOG_NAVG);
            code_frac <= aborted ? '0 : acc[LOG_NAVG-1:0];
          end else if (ack) begin
            valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_therm_to_code.sv
// Directed bench for therm_to_code: the driver queues expected results
// (latency, err, bubble, code, frac) and a negedge monitor checks them.
module tb_therm_to_code;
  import therm_to_code_pkg::*;

  localparam int EW = 14;  // {lat[4:0], err, bubble, code[4:0], frac[1:0]}

  logic        clk4 = 1'b0;
  logic        rst_n, start, ack;
  logic [15:0] T_in, Tb_in;
  logic        busy, valid, bubble, err;
  logic [4:0]  code_out;
  logic [1:0]  code_frac;

  therm_to_code dut (
    .clk4      (clk4),
    .rst_n     (rst_n),
    .start     (start),
    .ack       (ack),
    .T_in      (T_in),
    .Tb_in     (Tb_in),
    .busy      (busy),
    .valid     (valid),
    .code_out  (code_out),
    .code_frac (code_frac),
    .bubble    (bubble),
    .err       (err)
  );

  // Clock / reset
  always #5 clk4 = ~clk4;

  int cyc = 0;
  always @(posedge clk4) cyc <= cyc + 1;

  // Scoreboard state
  logic [EW-1:0] exp_q[$];
  int            n_vec = 0;
  int            n_bad = 0;
  int            start_cyc = 0;
  logic [15:0]   st[8];
  logic [15:0]   stb[8];

  function automatic logic [EW-1:0] mk_exp(input int lat, input logic e, input logic b,
                                           input logic [4:0] c, input logic [1:0] f);
    return {5'(lat), e, b, c, f};
  endfunction

  // Monitor: check each new result, then check it stays put while valid.
  logic          valid_q = 1'b0;
  logic [EW-1:0] cur, act;
  logic [8:0]    held;
  always @(negedge clk4) begin
    if (valid && !valid_q) begin
      n_vec++;
      act = {5'(cyc - start_cyc - 1), err, bubble, code_out, code_frac};
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_result: code=%0d err=%0b with nothing pending", code_out, err);
      end else begin
        cur = exp_q.pop_front();
        if (act !== cur) begin
          n_bad++;
          $display("FAIL result: lat=%0d err=%0b bub=%0b code=%0d frac=%0d, required lat=%0d err=%0b bub=%0b code=%0d frac=%0d",
                   act[13:9], act[8], act[7], act[6:2], act[1:0],
                   cur[13:9], cur[8], cur[7], cur[6:2], cur[1:0]);
        end
      end
      held = {err, bubble, code_out, code_frac};
    end else if (valid && valid_q) begin
      n_vec++;
      if ({err, bubble, code_out, code_frac} !== held) begin
        n_bad++;
        $display("FAIL hold: outputs %h changed while valid, required %h",
                 {err, bubble, code_out, code_frac}, held);
      end
    end
    valid_q = valid;
  end

  // Driver: start a measurement and present st/stb[j] ahead of sample j.
  task automatic drive_meas(input int n, input bit poke, input logic [EW-1:0] expv);
    exp_q.push_back(expv);
    @(negedge clk4);
    start = 1'b1; start_cyc = cyc;
    T_in = st[0]; Tb_in = stb[0];
    @(negedge clk4);
    start = 1'b0;
    for (int j = 1; j < n; j++) begin
      @(negedge clk4);
      start = (j == 1) ? poke : 1'b0;
      ack   = (j == 1) ? poke : 1'b0;
      @(negedge clk4);
      start = 1'b0; ack = 1'b0;
      T_in = st[j]; Tb_in = stb[j];
    end
  endtask

  task automatic wait_done(input int ack_delay, input bit with_start);
    int t = 0;
    while (!valid && t < 40) begin
      @(negedge clk4);
      t++;
    end
    if (!valid) begin
      n_vec++; n_bad++;
      $display("FAIL timeout: valid=%0b after %0d cycles, required 1", valid, t);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    repeat (ack_delay) @(negedge clk4);
    ack = 1'b1;
    if (with_start) start = 1'b1;
    @(negedge clk4);
    ack = 1'b0; start = 1'b0;
    n_vec++;
    if (valid !== 1'b0) begin
      n_bad++;
      $display("FAIL ack_release: valid=%0b after ack, required 0", valid);
    end
  endtask

  task automatic check_idle(input string name);
    bit bad = 1'b0;
    repeat (10) begin
      @(negedge clk4);
      if (busy || valid) bad = 1'b1;
    end
    n_vec++;
    if (bad) begin
      n_bad++;
      $display("FAIL %s: busy/valid rose=%0b, required 0", name, bad);
    end
  endtask

  task automatic fill(input logic [15:0] t);
    for (int j = 0; j < 8; j++) begin
      st[j] = t; stb[j] = ~t;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ack = 1'b0;
    T_in = 16'h0000; Tb_in = 16'hFFFF;
    repeat (3) @(negedge clk4);
    n_vec++;
    if ({busy, valid, err, bubble, code_out, code_frac} !== 11'd0) begin
      n_bad++;
      $display("FAIL reset: outputs=%h, required 0", {busy, valid, err, bubble, code_out, code_frac});
    end
    rst_n = 1'b1;
    @(negedge clk4);

    fill(16'h00FF); drive_meas(1, 1'b0, mk_exp(9, 0, 0, 8, 0));  wait_done(1, 1'b0);
    fill(16'h0000); drive_meas(1, 1'b0, mk_exp(9, 0, 0, 0, 0));  wait_done(0, 1'b0);
    fill(16'hFFFF); drive_meas(1, 1'b0, mk_exp(9, 0, 0, 16, 0)); wait_done(0, 1'b0);

    // Reset while in CHECK must clear the held code of 16 at once.
    @(negedge clk4);
    start = 1'b1; T_in = 16'h00FF; Tb_in = 16'hFF00;
    @(negedge clk4); start = 1'b0;
    @(negedge clk4);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, valid, err, bubble, code_out, code_frac} !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_mid_check: outputs=%h, required 0", {busy, valid, err, bubble, code_out, code_frac});
    end
    @(negedge clk4); rst_n = 1'b1;
    @(negedge clk4);

    fill(16'h00F7); st[0] = 16'h00F7; stb[0] = 16'hFF08;
    drive_meas(1, 1'b0, mk_exp(9, 0, 1, 8, 0)); wait_done(0, 1'b0);

    fill(16'h00FF); st[2] = 16'h01FF; stb[2] = 16'hFE00; st[3] = 16'h01FF; stb[3] = 16'hFE00;
    drive_meas(4, 1'b0, mk_exp(9, 0, 0, 8, 2)); wait_done(0, 1'b0);

    fill(16'h00FF); stb[0] = 16'h0000;
    drive_meas(1, 1'b0, mk_exp(7, 1, 0, 0, 0)); wait_done(5, 1'b0);

    fill(16'h00FF); stb[0] = 16'h0000;
    drive_meas(5, 1'b0, mk_exp(11, 0, 0, 8, 0)); wait_done(0, 1'b0);

    // start and ack pulsed mid-measurement are ignored.
    fill(16'h003F); drive_meas(4, 1'b1, mk_exp(9, 0, 0, 6, 0)); wait_done(2, 1'b0);
    check_idle("start_while_busy");

    // ack with start in DONE returns to IDLE without a new measurement.
    fill(16'h07FF); drive_meas(1, 1'b0, mk_exp(9, 0, 0, 11, 0)); wait_done(0, 1'b1);
    check_idle("ack_with_start");

    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL pending: %0d results never seen, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/therm_to_code.md
Name: therm_to_code

Overview:
- Reads back the 16-bit thermometer tap vector (T/Tb pair) of the delay-line control path and converts it to a binary code. This is the inverse of the 4-to-16 thermometer decoder.
- Per measurement: bubble-corrects NAVG samples, checks T/Tb complementarity, and averages the samples into an integer code plus a fractional remainder.
- Used by lock-monitor and calibration logic to confirm that the delay-line setting applied after SAR convergence matches the commanded code.
- Sits in the PTC clock domain, clocked by clk4.

Parameters:
- TW, 16, thermometer width (taps).
- NAVG, 4, good samples averaged per measurement; power of 2.
- LOG_NAVG, 2, log2(NAVG).
- MAX_RETRY, 3, consecutive T/Tb mismatches tolerated before the measurement aborts.

Ports:
- clk4  input  1  block clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin a measurement; honoured only in IDLE.
- ack  input  1  consumer acknowledge of a completed result; honoured only in DONE.
- T_in  input  TW  thermometer taps; bit i=1 for i<level.
- Tb_in  input  TW  complementary taps; must equal ~T_in.
- busy  output  1  high in SAMPLE/CHECK.
- valid  output  1  high in DONE; result stable.
- code_out  output  5  averaged level 0..16 = acc>>LOG_NAVG.
- code_frac  output  LOG_NAVG  acc[LOG_NAVG-1:0].
- bubble  output  1  sticky: a correction occurred in any sample of this measurement.
- err  output  1  measurement aborted on mismatch.

Behaviour:
- Reset: state=IDLE. busy, valid, code_out, code_frac, bubble, err all 0. Internal acc (7b), sample count, and retry count are 0. Reset is asynchronous and may abort any state.
- IDLE: on start=1, clear acc, cnt, retry, bubble_acc, then go to SAMPLE.
- SAMPLE (1 cycle): register T_in→T_r and Tb_in→Tb_r. Go to CHECK.
- CHECK (1 cycle), mismatch case (Tb_r != ~T_r):
  - retry++ and nothing is accumulated.
  - If retry reaches MAX_RETRY, go to DONE with err=1, code_out=0, code_frac=0.
  - Otherwise return to SAMPLE.
- CHECK, good sample:
  - retry cleared; acc += count; bubble_acc |= corrected; cnt++.
  - If cnt reaches NAVG, go to DONE with code_out=acc>>LOG_NAVG, code_frac=acc low bits, bubble=bubble_acc, err=0.
  - Otherwise go to SAMPLE.
- Bubble correction: c[i] = majority(T[i-1], T[i], T[i+1]), with boundary T[-1]=1 and T[TW]=0. count = popcount(c), range 0..16. corrected = (c != T_r).
- DONE: valid=1 and all outputs held until ack=1, then go to IDLE. Outputs keep their last values in IDLE until the next DONE.
- Latency with no errors: start sampled at edge k gives valid high after edge k+2*NAVG+1 (9 cycles for NAVG=4). Each mismatch adds 2 cycles.
- start in any state other than IDLE is ignored. ack outside DONE is ignored.
- ack and start together in DONE: go to IDLE and drop start; a fresh start is required.
- Arithmetic: acc is a 7-bit unsigned value (max 16*NAVG = 64). There is no overflow for NAVG≤4; NAVG>7 requires widening acc.

Decomposition:
- Shared package: TW, code width 5, the FSM state encoding (IDLE, SAMPLE, CHECK, DONE), and a MAX_RETRY default.
- One combinational sub-module, therm_bubble_count: inputs T, outputs count[4:0] and corrected. Holds the majority filter and popcount.

Test Plan:
- T_in=16'h00FF, Tb_in=16'hFF00 for all samples, pulse start → valid 9 cycles later; code_out=8, code_frac=0, bubble=0, err=0.
- Boundaries: T_in=16'h0000 (Tb=FFFF) → code_out=0. T_in=16'hFFFF (Tb=0000) → code_out=16, frac=0.
- Bubble: T_in=16'h00F7, Tb_in=16'hFF08 → code_out=8, bubble=1.
- Averaging: samples 00FF, 00FF, 01FF, 01FF (Tb complemented) → acc=34; code_out=8, code_frac=2.
- Mismatch: Tb_in=16'h0000 with T_in=16'h00FF held → err=1, code_out=0, valid after 2*MAX_RETRY+1=7 cycles. One corrupt sample followed by good ones → err=0, latency 11 cycles.
- Handshake and reset:
  - start asserted while busy → ignored.
  - ack delayed 5 cycles → outputs stable throughout.
  - ack+start together in DONE → IDLE, no new measurement.
  - rst_n low mid-CHECK → all outputs 0 immediately, IDLE.
